// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the timer and whatever loads and observes it.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] counter_out;
  logic             underflow_out;
  logic             done_out;
  logic             busy_out;

  modport master (
    output load, load_value, enable, auto_reload,
    input  counter_out, underflow_out, done_out, busy_out
  );

  modport slave (
    input  load, load_value, enable, auto_reload,
    output counter_out, underflow_out, done_out, busy_out
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter: one-cycle pulse at terminal count, then either a sticky
// done flag or an automatic reload for periodic ticks.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             underflow_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] count_dec_d;
  logic             at_terminal;

  // Zero is never decremented: the count leaves 1 by reload or by stopping.
  assign at_terminal = (count_q == ONE);
  assign count_dec_d = count_q - ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      if (bus.load) begin
        reload_q <= bus.load_value;
        count_q  <= bus.load_value;
        if (bus.load_value != '0) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end else begin
          // A zero load is an immediate terminal count.
          state_q     <= DONE;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          underflow_q <= 1'b1;
        end
      end else if (state_q == RUN && bus.enable) begin
        if (at_terminal) begin
          underflow_q <= 1'b1;
          if (bus.auto_reload) begin
            count_q <= reload_q;
          end else begin
            count_q <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end else begin
          count_q <= count_dec_d;
        end
      end
    end
  end

  assign bus.counter_out   = count_q;
  assign bus.underflow_out = underflow_q;
  assign bus.done_out      = done_q;
  assign bus.busy_out      = busy_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a ticks-since-load model.
module tb_countdown_timer;

  localparam int W = 4;

  logic clock = 1'b0;
  logic reset;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model: the count is the reload value minus enabled ticks seen this period.
  int m_rel   = 0;
  int m_ticks = 0;
  bit m_run   = 1'b0;
  bit m_done  = 1'b0;
  bit m_uf    = 1'b0;

  always @(posedge clock) begin
    int  rel, ticks;
    bit  run, done, uf;
    rel = m_rel; ticks = m_ticks; run = m_run; done = m_done; uf = 1'b0;
    if (reset) begin
      rel = 0; ticks = 0; run = 1'b0; done = 1'b0;
    end else if (bus.load) begin
      rel   = int'(bus.load_value);
      ticks = 0;
      run   = (rel != 0);
      done  = (rel == 0);
      uf    = (rel == 0);
    end else if (run && bus.enable) begin
      ticks = ticks + 1;
      if (ticks == rel) begin
        uf = 1'b1;
        if (bus.auto_reload) ticks = 0;
        else begin
          run  = 1'b0;
          done = 1'b1;
        end
      end
    end
    m_rel <= rel; m_ticks <= ticks; m_run <= run; m_done <= done; m_uf <= uf;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model.count", int'(bus.counter_out), m_run ? (m_rel - m_ticks) : 0);
    chk("model.underflow", int'(bus.underflow_out), int'(m_uf));
    chk("model.done", int'(bus.done_out), int'(m_done));
    chk("model.busy", int'(bus.busy_out), int'(m_run));
  endtask

  task automatic expect_out(input string name, input int cnt, input int uf,
                            input int dn, input int bz);
    chk({name, ".count"}, int'(bus.counter_out), cnt);
    chk({name, ".underflow"}, int'(bus.underflow_out), uf);
    chk({name, ".done"}, int'(bus.done_out), dn);
    chk({name, ".busy"}, int'(bus.busy_out), bz);
  endtask

  // Apply inputs at a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic step(input bit rst, input bit ld, input int lv, input bit en,
                      input bit ar, input bit verbose);
    reset           = rst;
    bus.load        = ld;
    bus.load_value  = W'(lv);
    bus.enable      = en;
    bus.auto_reload = ar;
    @(negedge clock);
    check_model();
    if (verbose)
      $display("t=%0t rst=%0b ld=%0b lv=%0d en=%0b ar=%0b -> cnt=%0d uf=%0b done=%0b busy=%0b",
               $time, rst, ld, lv, en, ar, bus.counter_out, bus.underflow_out,
               bus.done_out, bus.busy_out);
  endtask

  initial begin
    reset = 1'b1;
    bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0; bus.auto_reload = 1'b0;
    @(negedge clock);

    // Reset dominates load and enable.
    step(1, 1, 9, 1, 0, 1);
    expect_out("reset", 0, 0, 0, 0);

    // Load 3, enable held high, no reload.
    step(0, 1, 3, 1, 0, 1); expect_out("l3.load", 3, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1); expect_out("l3.c2", 2, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1); expect_out("l3.c1", 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1); expect_out("l3.tc", 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1); expect_out("l3.hold", 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 1); expect_out("l3.hold2", 0, 0, 1, 0);

    // Periodic mode with reload value 2.
    step(0, 1, 2, 1, 1, 1); expect_out("ar.load", 2, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1); expect_out("ar.c1", 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1); expect_out("ar.r1", 2, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1); expect_out("ar.c1b", 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1); expect_out("ar.r2", 2, 1, 0, 1);

    // Reload value 1: underflow held high, one pulse per cycle.
    step(0, 1, 1, 1, 1, 1); expect_out("ar1.load", 1, 0, 0, 1);
    step(0, 0, 0, 1, 1, 1); expect_out("ar1.p1", 1, 1, 0, 1);
    step(0, 0, 0, 1, 1, 1); expect_out("ar1.p2", 1, 1, 0, 1);

    // Zero load terminates immediately.
    step(0, 1, 0, 1, 0, 1); expect_out("l0", 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 1); expect_out("l0.after", 0, 0, 1, 0);

    // Load 15 with enable toggling: terminal count on the 15th enabled tick.
    step(0, 1, 15, 0, 0, 1); expect_out("l15.load", 15, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      bit en;
      int ticks;
      en    = (i % 2 == 0);
      ticks = i / 2 + 1;
      step(0, 0, 0, en, 0, 1);
      if (ticks < 15) expect_out("l15.tick", 15 - ticks, 0, 0, 1);
      else if (i == 28) expect_out("l15.tc", 0, 1, 1, 0);
      else expect_out("l15.done", 0, 0, 1, 0);
    end

    // Load coincident with terminal count wins; then reset mid-count.
    step(0, 1, 2, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1); expect_out("lt.c1", 1, 0, 0, 1);
    step(0, 1, 5, 1, 0, 1); expect_out("lt.load", 5, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1); expect_out("lt.c4", 4, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1); expect_out("lt.reset", 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1); expect_out("lt.idle", 0, 0, 0, 0);

    // Randomized traffic: short periods so terminal counts happen often.
    begin
      bit ar;
      ar = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit rst, ld, en;
        int lv;
        rst = ($urandom_range(0, 99) == 0);
        ld  = ($urandom_range(0, 7) == 0);
        lv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
        en  = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) ar = ~ar;
        step(rst, ld, lv, en, ar, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter timer, the decrementing counterpart to the team's 4-bit up-counter with overflow flag. Software or control logic loads a start value, and the block decrements on each enabled cycle. On reaching zero it raises a one-cycle terminal-count pulse and a sticky done flag, or optionally reloads itself for periodic operation. It sits beside the up-counter in the timing/control path and drives timeouts and periodic ticks.

## Interface
- WIDTH, 4, counter and load-value width (≥2)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; reset reset, synchronous, active-high; clock clock
- load  in  1  capture load_value, start/restart countdown
- load_value  in  WIDTH  start and reload value
- enable  in  1  count-tick qualifier; one decrement per cycle when high
- auto_reload  in  1  level; when high at terminal count, reload instead of stopping
- counter_out  out  WIDTH  current count
- underflow_out  out  1  one-cycle terminal-count pulse
- done_out  out  1  sticky, set on non-reload terminal count
- busy_out  out  1  high while in RUN

## Operation
- States: IDLE, RUN, DONE. Internal reload_reg[WIDTH] captured on every load.
- Priority per cycle: reset > load > enable.
- Reset: state IDLE, counter_out=0, reload_reg=0, underflow_out=0, done_out=0, busy_out=0.
- load (any state): reload_reg<=load_value, done_out<=0.
  - load_value≠0: counter_out<=load_value, go RUN.
  - load_value=0: counter_out<=0, go DONE, done_out<=1, underflow_out pulses.
- RUN, enable=1, counter_out>1: counter_out<=counter_out−1.
- RUN, enable=1, counter_out=1 (terminal count): underflow_out<=1 for one cycle.
  - auto_reload=1: counter_out<=reload_reg, stay RUN. Period is exactly reload_reg enabled ticks.
  - auto_reload=0: counter_out<=0, go DONE, done_out<=1.
- RUN, enable=0: hold all state.
- IDLE/DONE: enable ignored, counter holds, and only load leaves. DONE holds done_out=1 until load or reset.
- Arithmetic: decrement is unsigned modulo 2^WIDTH. Wrap never occurs because 0 is never decremented. Max load is 2^WIDTH−1 (15 for WIDTH=4).
- busy_out = (state==RUN), registered.

## Timing
- All outputs registered and update on the edge following the qualifying input. No combinational input-to-output paths.
- Load-to-first-decrement: load at edge N puts counter_out=load_value after N; a decrement requires enable at a later edge.
- underflow_out is high exactly one cycle per terminal count. For back-to-back periods with reload_reg=1 and enable constant, it stays high continuously, one pulse per cycle.
- load coincident with terminal count: load wins, with no underflow pulse and no done.
- Reset mid-RUN: all outputs 0 after the edge, and any in-flight pulse is cancelled.
- auto_reload is sampled only at the terminal-count edge, so changes mid-count are legal.

## Structure
- Shared package countdown_pkg: state enum (IDLE, RUN, DONE) and default WIDTH constant.
- Single module, no sub-module. Next-state/next-count logic and registers live in one process plus a small combinational decode for terminal count (counter_out==1).

## Test plan
- Reset with load=1, enable=1 asserted → after the edge, counter_out=0, underflow_out=0, done_out=0, busy_out=0.
- Load 3, enable held high → counter_out 3,2,1,0; underflow_out high only in the cycle counter_out becomes 0; done_out=1 and busy_out=0 thereafter; further enables leave it at 0.
- auto_reload=1, load 2, enable high → counter_out 2,1,2,1,…; underflow_out pulses every 2nd cycle; done_out stays 0 and busy_out stays 1.
- Load 0 → next cycle done_out=1, underflow_out=1 for one cycle, counter_out=0, busy_out=0.
- Load 15, enable toggling 1,0,1,0 → counter_out decrements only on enabled cycles; terminal count arrives after exactly 15 enabled ticks.
- In RUN at count 1, assert load=1 (value 5) and enable=1 together → counter_out=5, no underflow pulse, done_out=0. Then assert reset mid-count → all outputs 0.
